// File: rtl/pc_lut_encoder.sv
// Branch-target LUT encoder: maps a D-bit jump target to the LUT index holding it, allocating on a miss.
// Build option PC_LUT_ENC_PARALLEL_EN: compare every entry in one SEARCH cycle instead of scanning one per cycle.
module pc_lut_encoder #(
  parameter int D = 10,
  parameter int N = 16,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_target,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [A-1:0] rsp_index,
  output logic         rsp_hit,
  output logic         rsp_full,
  output logic [A:0]   count,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_target
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [A:0] CAP = (A+1)'(N);

  logic [1:0]   state;
  logic [D-1:0] tgt;
  // Sized to the full index space so every rd_addr selects a real entry; slots at or above N stay zero.
  logic [D-1:0] lut [2**A];

  logic         found;
  logic [A-1:0] found_idx;

`ifdef PC_LUT_ENC_PARALLEL_EN
  // Lowest valid matching entry wins, so walk from the top down and let lower hits overwrite.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found     = 1'b0;
    found_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (((A+1)'(i) < count) && (lut[i] == tgt)) begin
        found     = 1'b1;
        found_idx = A'(i);
      end
    end
  end
`else
  logic [A-1:0] idx;
  logic         scan_done;

  always_comb begin
    found     = ((A+1)'(idx) < count) && (lut[idx] == tgt);
    found_idx = idx;
    scan_done = ((A+1)'(idx) + (A+1)'(1)) >= count;
  end
`endif

  assign req_ready = reset_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rd_target = lut[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state     <= IDLE;
      count     <= '0;
      tgt       <= '0;
      rsp_index <= '0;
      rsp_hit   <= 1'b0;
      rsp_full  <= 1'b0;
`ifndef PC_LUT_ENC_PARALLEL_EN
      idx       <= '0;
`endif
      // NOTE: the table lives in flops and is cleared here, because unwritten entries must read back as zero.
      for (int i = 0; i < 2**A; i++) begin
        lut[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tgt   <= req_target;
`ifndef PC_LUT_ENC_PARALLEL_EN
            idx   <= '0;
`endif
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (found) begin
            rsp_index <= found_idx;
            rsp_hit   <= 1'b1;
            rsp_full  <= 1'b0;
            state     <= RESP;
`ifndef PC_LUT_ENC_PARALLEL_EN
          end else if (!scan_done) begin
            idx <= idx + A'(1);
`endif
          end else if (count < CAP) begin
            lut[count[A-1:0]] <= tgt;
            rsp_index         <= count[A-1:0];
            rsp_hit           <= 1'b0;
            rsp_full          <= 1'b0;
            count             <= count + (A+1)'(1);
            state             <= RESP;
          end else begin
            // Table full: report it without touching any entry.
            rsp_index <= '0;
            rsp_hit   <= 1'b0;
            rsp_full  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_lut_encoder.sv
// Self-checking bench for pc_lut_encoder: directed scenarios plus randomized traffic against a queue-based table model.
module tb_pc_lut_encoder;
  localparam int D = 10;
  localparam int N = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         req_valid;
  logic         req_ready;
  logic [D-1:0] req_target;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [A-1:0] rsp_index;
  logic         rsp_hit;
  logic         rsp_full;
  logic [A:0]   count;
  logic [A-1:0] rd_addr;
  logic [D-1:0] rd_target;

  always #5 clk = ~clk;

  pc_lut_encoder #(.D(D), .N(N), .A(A)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_index(rsp_index),
    .rsp_hit(rsp_hit), .rsp_full(rsp_full), .count(count),
    .rd_addr(rd_addr), .rd_target(rd_target)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference table: position in the queue is the LUT index.
  logic [D-1:0] model_q [$];
  logic [D-1:0] pool [20];

  logic [A-1:0] got_idx;
  int           got_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_table_zero(input string tag);
    for (int i = 0; i < 2**A; i++) begin
      rd_addr = A'(i);
      #1;
      check(tag, rd_target, 0);
    end
  endtask

  // One full request/response; expectations come from the queue model and the latency rules.
  task automatic transact(input logic [D-1:0] t, input int hold);
    int           k;
    int           cnt_before;
    int           exp_lat;
    logic [A-1:0] e_idx;
    logic         e_hit;
    logic         e_full;
    logic [D-1:0] prev_rd;

    k = -1;
    foreach (model_q[i]) if (k < 0 && model_q[i] == t) k = i;
    cnt_before = model_q.size();
    if (k >= 0) begin
      e_idx = A'(k); e_hit = 1'b1; e_full = 1'b0; exp_lat = k + 1;
    end else if (cnt_before < N) begin
      e_idx = A'(cnt_before); e_hit = 1'b0; e_full = 1'b0;
      exp_lat = (cnt_before > 0) ? cnt_before : 1;
      model_q.push_back(t);
    end else begin
      e_idx = '0; e_hit = 1'b0; e_full = 1'b1; exp_lat = N;
    end
`ifdef PC_LUT_ENC_PARALLEL_EN
    exp_lat = 1;
`endif

    check("req_ready_idle", req_ready, 1);
    rd_addr    = e_idx;
    req_valid  = 1'b1;
    req_target = t;
    step();
    req_valid  = 1'b0;
    req_target = D'($urandom);
    got_lat    = 0;
    prev_rd    = rd_target;
    while (!rsp_valid && got_lat < 64) begin
      prev_rd = rd_target;
      step();
      got_lat++;
    end
    check("rsp_latency", got_lat, exp_lat);
    got_idx = rsp_index;
    check("rsp_index", rsp_index, e_idx);
    check("rsp_hit", rsp_hit, e_hit);
    check("rsp_full", rsp_full, e_full);
    check("count", count, model_q.size());
    check("req_ready_resp", req_ready, 0);
    if (!e_full) begin
      check("rd_target_new", rd_target, t);
      // A fresh allocation must still show the old (zero) contents before the write edge.
      if (!e_hit) check("rd_target_old", prev_rd, 0);
    end

    for (int h = 0; h < hold; h++) begin
      if (h == hold / 2) begin
        req_valid  = 1'b1;
        req_target = D'($urandom);
      end
      step();
      req_valid = 1'b0;
      check("hold_valid", rsp_valid, 1);
      check("hold_index", rsp_index, e_idx);
      check("hold_hit", rsp_hit, e_hit);
      check("hold_full", rsp_full, e_full);
      check("hold_req_ready", req_ready, 0);
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_done", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check("count_after", count, model_q.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_q.delete();
    check("clear_count", count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    req_valid  = 1'b0;
    req_target = '0;
    rsp_ready  = 1'b0;
    rd_addr    = '0;

    // Reset state.
    repeat (2) step();
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_count", count, 0);
    reset_n = 1'b1;
    #1;
    check("release_req_ready", req_ready, 1);
    check("reset_rsp_index", rsp_index, 0);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_rsp_full", rsp_full, 0);
    check_table_zero("reset_rd_target");

    // First allocation into an empty table.
    transact(10'h00B, 0);
    check("first_idx", got_idx, 0);
    rd_addr = '0;
    #1;
    check("first_rd", rd_target, 10'h00B);

    // Hit in the middle of a four-entry table.
    transact(10'h050, 0);
    transact(10'h044, 0);
    transact(10'h071, 0);
    transact(10'h044, 1);
    check("mid_hit_idx", got_idx, 2);

    // Fill to capacity, overflow, then hit the last entry.
    do_clear();
    for (int i = 0; i < N; i++) transact(D'(10'h100 + i), 0);
    transact(10'h3FF, 0);
    check("full_count", count, N);
    for (int i = 0; i < N; i++) begin
      rd_addr = A'(i);
      #1;
      check("full_entry", rd_target, 10'h100 + i);
    end
    transact(10'h10F, 0);
    check("last_hit_idx", got_idx, 15);

    // Backpressure with an ignored request pulse in the middle.
    transact(10'h105, 5);
    transact(10'h3FF, 5);

    // Clear while searching drops the pending response.
    do_clear();
    transact(10'h011, 0);
    transact(10'h022, 0);
    transact(10'h033, 0);
    req_valid  = 1'b1;
    req_target = 10'h3AA;
    step();
    req_valid  = 1'b0;
    check("search_no_rsp", rsp_valid, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_q.delete();
    check("clear_rsp_valid", rsp_valid, 0);
    check("clear_count_search", count, 0);
    check("clear_req_ready", req_ready, 1);
    step();
    check("clear_stays_idle", rsp_valid, 0);
    transact(10'h050, 0);
    check("post_clear_idx", got_idx, 0);

    // Randomized traffic over a small pool so hits, misses and overflow all occur.
    do_clear();
    pool[0] = '0;
    for (int i = 1; i < 20; i++) pool[i] = D'($urandom);
    for (int n = 0; n < 80; n++) begin
      if (n == 40) do_clear();
      transact(pool[$urandom_range(0, 19)], int'($urandom_range(0, 2)));
    end

    // Reset while a response is pending.
    req_valid  = 1'b1;
    req_target = 10'h2AB;
    step();
    req_valid  = 1'b0;
    got_lat    = 0;
    while (!rsp_valid && got_lat < 64) begin
      step();
      got_lat++;
    end
    check("pre_reset_rsp_valid", rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_req_ready", req_ready, 0);
    step();
    reset_n = 1'b1;
    model_q.delete();
    check("rreset_rsp_valid", rsp_valid, 0);
    check("rreset_count", count, 0);
    check("rreset_index", rsp_index, 0);
    check("rreset_hit", rsp_hit, 0);
    check("rreset_full", rsp_full, 0);
    #1;
    check("rreset_req_ready", req_ready, 1);
    check_table_zero("rreset_rd_target");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_lut_encoder.md
Name: pc_lut_encoder

Overview:
- Reverse side of the branch-target LUT: takes a D-bit absolute jump target and returns the 4-bit LUT index that the decode-side lookup maps back to that target.
- Allocates a new entry on a miss.
- Sits between the program loader / assembler-assist path and the branch-target table.
- Exposes a combinational read port so the fetch side sees the same contents it built.

Parameters:
- D, 10, target (PC) width in bits.
- N, 16, number of table entries; must be a power of two ≤ 2**A.
- A, 4, index width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- clear  input  1  synchronous table flush, active-high
- req_valid  input  1  request target valid
- req_ready  output  1  encoder can accept a request
- req_target  input  D  target to encode
- rsp_valid  output  1  response valid; held until accepted
- rsp_ready  input  1  consumer accepts response
- rsp_index  output  A  index holding the target
- rsp_hit  output  1  1 = found existing entry; 0 = newly allocated
- rsp_full  output  1  1 = miss with table full; no entry written, rsp_index = 0
- count  output  A+1  number of valid entries, 0..N
- rd_addr  input  A  decode-side read index
- rd_target  output  D  table[rd_addr], combinational; 0 for unwritten entries

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, count=0, all table entries=0.
  - rsp_valid=0, rsp_index=0, rsp_hit=0, rsp_full=0.
  - req_ready=0 while reset_n=0; req_ready=1 in the first cycle after release.
  - Reset mid-search or mid-response aborts the transaction silently.
- FSM states IDLE, SEARCH, RESP:
  - IDLE: req_ready=1. If req_valid, latch req_target, set scan pointer idx=0, go to SEARCH.
  - SEARCH: req_ready=0. Each cycle, if idx<count and table[idx]==latched target:
    - rsp_index=idx, hit=1, go to RESP.
    - Otherwise, if idx+1<count: idx++.
    - Otherwise (end of table, including count==0):
      - If count<N: table[count]=target, rsp_index=count, hit=0, count++, go to RESP.
      - If count==N: rsp_full=1, rsp_index=0, hit=0, table unchanged, go to RESP.
  - RESP: rsp_valid=1 with index/hit/full stable until rsp_valid&rsp_ready at an edge, then go to IDLE.
    - A new request is not accepted in the same cycle as the response handshake (req_ready=0 in RESP).
- Latency, accept edge = E0:
  - Hit at entry k: rsp_valid high after edge E0+k+1.
  - Miss: rsp_valid high after edge E0+max(count,1).
- Uniqueness: a target is never stored twice. The first match is the lowest index.
- Targets wider than D do not exist; comparison is full D-bit equality. Target 0 is a legal value.
- clear: at an edge, same effect as reset on count, table, and state, except req_ready is not forced low.
  - clear in SEARCH or RESP drops the pending response (rsp_valid→0 next cycle, no handshake required).
  - reset_n=0 takes priority over clear.
- A table write and a rd_addr read of the same entry in the same cycle: rd_target shows the old value until after the edge.
- count saturates at N and never wraps.

Optional Feature:
- Macro PC_LUT_ENC_PARALLEL_EN.
- Defined:
  - SEARCH compares all N entries in a single cycle, with lowest matching valid index winning.
  - Allocate/full decision is made in that same cycle.
  - rsp_valid is always high after edge E0+1, regardless of hit position or count.
- Undefined: sequential one-entry-per-cycle scan as above (smaller area).
- All other behaviour is identical.

Test Plan:
- Reset, then request 0x00B:
  - rsp_valid after E0+1, rsp_index=0, rsp_hit=0, rsp_full=0, count=1.
  - rd_addr=0 gives rd_target=0x00B.
- Load 0x00B, 0x050, 0x044, 0x071, then request 0x044:
  - rsp_index=2, rsp_hit=1, count stays 4.
  - Sequential build: rsp_valid after E0+3. PARALLEL_EN build: after E0+1.
- Fill 16 distinct targets 0x100..0x10F, then request 0x3FF:
  - rsp_full=1, rsp_index=0, count=16, all entries unchanged.
  - Then request 0x10F: hit, index 15.
- Response backpressure:
  - Hold rsp_ready=0 for 5 cycles: rsp_valid and fields stable, req_ready=0, a req_valid pulse is ignored.
  - Release rsp_ready: IDLE the next cycle.
- Assert clear during SEARCH with count=3:
  - Next cycle rsp_valid=0, count=0, state IDLE.
  - A follow-up request 0x050 returns index 0, hit=0.
- Drive reset_n=0 for one cycle while in RESP:
  - All outputs return to reset values, and rd_target=0 for every rd_addr.
